// File: rtl/memory_blockram_dp.sv
// Single-clock block RAM: port A read/write with lane enables, port B read-only.
// Self-clears to INIT_VALUE after reset or clr, with optional output register.
module memory_blockram_dp #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10,
  parameter int LANE_WIDTH = 9,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  output logic                             ready,
  input  logic                             a_en,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_din,
  output logic [DATA_WIDTH-1:0]            a_dout,
  output logic                             a_valid,
  input  logic                             b_en,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  output logic [DATA_WIDTH-1:0]            b_dout,
  output logic                             b_valid
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clear_wr;
  logic                  a_acc;
  logic                  b_acc;
  logic [DATA_WIDTH-1:0] a_old;
  logic [DATA_WIDTH-1:0] a_new;
  logic [DATA_WIDTH-1:0] b_old;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  a_qv;
  logic                  b_qv;

  assign ready    = (state == IDLE);
  assign clear_wr = (state == CLEAR) && !clr;
  assign a_acc    = ready && a_en;
  assign b_acc    = ready && b_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      CLEAR: begin
        if (clr) begin
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + ONE;
          if (cnt == '1) state_nx = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = CLEAR;
        cnt_nx   = '0;
      end
    endcase
  end

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  always_comb begin
    a_new = a_old;
    for (int i = 0; i < LANES; i++) begin
      if (a_we[i]) a_new[i*LANE_WIDTH +: LANE_WIDTH] = a_din[i*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // clear and user writes never share a cycle since users need ready
  always_ff @(posedge clk) begin
    if (clear_wr) begin
      mem[cnt] <= INIT_VALUE;
    end else if (a_acc && (|a_we)) begin
      mem[a_addr] <= a_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      a_qv <= 1'b0;
      b_qv <= 1'b0;
    end else begin
      a_qv <= a_acc;
      b_qv <= b_acc;
      if (a_acc) a_q <= (RD_MODE != 0) ? a_new : a_old;
      if (b_acc) b_q <= b_old;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_dout  <= '0;
          b_dout  <= '0;
          a_valid <= 1'b0;
          b_valid <= 1'b0;
        end else begin
          a_dout  <= a_q;
          b_dout  <= b_q;
          a_valid <= a_qv;
          b_valid <= b_qv;
        end
      end
    end else begin : g_noreg
      assign a_dout  = a_q;
      assign b_dout  = b_q;
      assign a_valid = a_qv;
      assign b_valid = b_qv;
    end
  endgenerate

endmodule
